// File: rtl/gpio_mem_responder_if.sv
// gpio_mem_responder_if: mprj_io pad bundle between the host-facing pads and the responder.
interface gpio_mem_responder_if;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    modport master (output io_in, input io_out, input io_oeb);
    modport slave (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/gpio_mem_responder.sv
// gpio_mem_responder: pad-driven 64x8 memory responder, synchronizes host strobes and serves reads/writes.
module gpio_mem_responder #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int DRIVE_TIMEOUT = 1024
) (
    input logic wb_clk_i,
    input logic wb_rst_i,
    gpio_mem_responder_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(DRIVE_TIMEOUT + 2);
    typedef enum logic [2:0] {IDLE, SETTLE, WRITE, READ, DRIVE, WAIT} state_t;
    state_t state;
    logic [15:0] raw;
    logic [15:0] sync_q [SYNC_STAGES];
    logic rd_s, wr_s, rd_prev, wr_prev, rd_rise, wr_rise;
    logic [7:0] data_s, wdata, rdata;
    logic [5:0] addr_s, addr;
    logic [7:0] mem [64];
    logic [SW-1:0] scnt;
    logic [TW-1:0] tcnt;
    logic op_w, busy, drv, err;
    logic unused_io;
    assign raw = {bus.io_in[30:25], bus.io_in[15:8], bus.io_in[3], bus.io_in[0]};
    assign unused_io = ^{bus.io_in[37:31], bus.io_in[24:16], bus.io_in[7:4], bus.io_in[2:1]};
    assign rd_s = sync_q[SYNC_STAGES-1][0];
    assign wr_s = sync_q[SYNC_STAGES-1][1];
    assign data_s = sync_q[SYNC_STAGES-1][9:2];
    assign addr_s = sync_q[SYNC_STAGES-1][15:10];
    // Bits [6:4] are status outputs and never tristate; data pads drive only while serving a read.
    assign bus.io_out = {22'b0, drv ? rdata : 8'h00, 1'b0, err, busy, drv, 4'b0};
    assign bus.io_oeb = {22'h3FFFFF, {8{~drv}}, 1'b1, 3'b000, 4'hF};
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            state <= IDLE;
            {rd_prev, wr_prev, rd_rise, wr_rise} <= '0;
            {op_w, busy, drv, err} <= '0;
            {wdata, rdata, addr} <= '0;
            scnt <= '0;
            tcnt <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            rd_prev <= rd_s;
            wr_prev <= wr_s;
            // Registered rise pulses keep io_in fully isolated from the FSM decode.
            rd_rise <= rd_s & ~rd_prev;
            wr_rise <= wr_s & ~wr_prev;
            if (state != IDLE && op_w && rd_rise) err <= 1'b1;
            case (state)
                IDLE: if (wr_rise || rd_rise) begin
                    state <= SETTLE;
                    busy <= 1'b1;
                    op_w <= wr_rise;
                    scnt <= '0;
                    if (wr_rise && rd_rise) err <= 1'b1;
                end
                SETTLE: if (scnt == SW'(SETTLE_CYCLES - 1)) begin
                    addr <= addr_s;
                    wdata <= data_s;
                    state <= op_w ? WRITE : READ;
                end else begin
                    scnt <= scnt + 1'b1;
                end
                WRITE: begin
                    mem[addr] <= wdata;
                    state <= WAIT;
                end
                READ: begin
                    rdata <= mem[addr];
                    drv <= 1'b1;
                    tcnt <= '0;
                    state <= DRIVE;
                end
                DRIVE: if (!rd_s) begin
                    drv <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end else if (DRIVE_TIMEOUT != 0 && tcnt == TW'(DRIVE_TIMEOUT - 1)) begin
                    drv <= 1'b0;
                    state <= WAIT;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                WAIT: if (!rd_s && !wr_s) begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
